ins_decoder: RTL and testbench
==============================

INS_DECODER -- requirements
Module: ins_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port InsM, input, 8 bits [15:8]: instruction high byte; [15:11] is the opcode, [10:8] is the branch condition.
REQ-004 SHALL have port InsL, input, 2 bits: instruction bits [1:0], the function code.
REQ-005 SHALL have port Cnt, input, 3 bits: step counter, external; the counter logic clears it after any cycle with Buff_PC=1.
REQ-006 SHALL have port PSW_NZC, input, 2 bits: [1]=Z flag, [0]=C flag.
REQ-007 SHALL have port Flag, output, 1 bit: ALU uses carry-in (ADC, SBB).
REQ-008 SHALL have port ALUop, output, 1 bit: 0=add, 1=subtract.
REQ-009 SHALL have port Buff_PSW, output, 1 bit: PSW write enable.
REQ-010 SHALL have port Branch, output, 1 bit: branch-class instruction in its execute step.
REQ-011 SHALL have port Jump, output, 2 bits: next-PC source; 00=PC+1, 01=PC+disp, 10=register, 11=hold current PC.
REQ-012 SHALL have port Buff_PC, output, 1 bit: PC write enable; marks the last step of an instruction.
REQ-013 SHALL have port Buff_MEMIns, output, 1 bit: instruction register load.
REQ-014 SHALL have port MEMresource, output, 1 bit: memory address source; 0=PC, 1=ALU result.
REQ-015 SHALL have port ALUorNot, output, 1 bit: write-back data source; 1=ALU, 0=LI/MOV path.
REQ-016 SHALL have port LIorMOV, output, 1 bit: LI/MOV path source; 0=immediate, 1=register.
REQ-017 SHALL have port WE_MEM, output, 1 bit: data memory write enable.
REQ-018 SHALL have port WE_RF, output, 1 bit: register file write enable.
REQ-019 SHALL have port PCplus1orWB, output, 1 bit: register file write data; 1=PC+1 (link), 0=normal write-back.
REQ-020 SHALL have port LI, output, 1 bit: immediate byte lane; 0=low (LLI), 1=high (LHI).
REQ-021 SHALL have port WBresource, output, 1 bit: write-back source; 0=ALU/LI path, 1=memory.
REQ-022 SHALL have port RBresource, output, 1 bit: read port B address; 0=Rb field, 1=Rd field (store data).
REQ-023 SHALL have port OprandB, output, 1 bit: ALU operand B; 0=register, 1=immediate.
REQ-024 SHALL have port Done, output, 1 bit: processor halted (sticky).

Function
REQ-025 SHALL hold state only in two registers: IR {InsM, InsL}, loaded on the clk edge where Cnt==0 and Rst==0, and Done; all outputs SHALL be combinational from Cnt, IR, PSW_NZC and Done.
REQ-026 SHALL decode from IR: 00000 ALU (InsL 00 ADD, 01 ADC, 10 SUB, 11 SBB); 00001 LHI; 00010 LLI; 00011 LDRri; 00100 LDRrr; 00101 STRri; 00110 STRrr (InsL 00) or CMP (InsL 01); 00111 ADDI; 01000 SUBI; 01011 MOV; 10000 JMP; 10001 JALrl; 10010 JALrr; 10011 JR; 11000 Bcond; 11001 BAL; 11100 OutR (InsL 00) or HLT (InsL 01).
REQ-027 SHALL drive every output 0 by default; Jump SHALL default to 00.
REQ-028 SHALL drive, at Cnt=0 with Done=0: Buff_MEMIns=1 and MEMresource=0; all outputs SHALL be 0 at Cnt=1 (decode step).
REQ-029 SHALL drive, for ALU/CMP/ADDI/SUBI: at Cnt=2 and Cnt=3, ALUorNot=1, ALUop=1 for SUB/SBB/CMP/SUBI, Flag=1 for ADC/SBB, OprandB=1 for ADDI/SUBI; at Cnt=3, Buff_PSW=1, Buff_PC=1, and WE_RF=1 (except CMP).
REQ-030 SHALL drive, for LHI/LLI/MOV at Cnt=2: WE_RF=1 and Buff_PC=1; LI=1 for LHI only; LIorMOV=1 for MOV only.
REQ-031 SHALL drive, for LDR: OprandB=1 for ri at Cnt 2-4; MEMresource=1 at Cnt 3-4; at Cnt=4, WBresource=1, WE_RF=1 and Buff_PC=1.
REQ-032 SHALL drive, for STR: OprandB=1 for ri and RBresource=1 at Cnt 2-3; at Cnt=3, MEMresource=1, WE_MEM=1 and Buff_PC=1.
REQ-033 SHALL drive, for Bcond/BAL at Cnt=2: Branch=1 and Buff_PC=1; Jump=01 if taken, else 00.
REQ-034 SHALL take a branch as follows: InsM[10:8] 000=BNE (Z=0), 001=BEQ (Z=1), 010=BCS (C=1), 011=BCC (C=0); BAL is always taken.
REQ-035 SHALL drive, for JMP/JALrl at Cnt=2: Jump=01 and Buff_PC=1; for JALrr/JR: Jump=10 and Buff_PC=1.
REQ-036 SHALL additionally drive, for JAL* at Cnt=2: WE_RF=1 and PCplus1orWB=1.
REQ-037 SHALL treat OutR and undefined opcodes/functions as NOP: Buff_PC=1 at Cnt=2, no other enables.
REQ-038 SHALL execute HLT at Cnt=2 as follows: Jump=11 and Buff_PC=1, and Done is set on that edge.
REQ-039 SHALL, while Done=1: force Buff_PC=1 and Jump=11 at every step; drive all other outputs except Done to 0; keep IR unchanged.
REQ-040 SHALL drive all outputs 0 for any Cnt value beyond an instruction's last step.

Reset
REQ-041 SHALL, on a clk edge with Rst=1: clear IR to 0 (decodes as ADD) and clear Done.
REQ-042 SHALL drive all outputs 0 while Rst=1, including Buff_PC and Done.

Verification
REQ-043 SHALL cover reset: Rst=1 for 2 cycles -> all outputs 0; after release with Cnt=0 -> Buff_MEMIns=1.
REQ-044 SHALL cover ADD: InsM=00000xxx, InsL=00 -> Cnt=2: ALUorNot=1, ALUop=0; Cnt=3: WE_RF=1, Buff_PSW=1, Buff_PC=1, Jump=00.
REQ-045 SHALL cover LDRri: InsM=00011xxx -> Cnt=3: MEMresource=1; Cnt=4: WE_RF=1, WBresource=1, Buff_PC=1.
REQ-046 SHALL cover BEQ: InsM=11000001 -> with PSW_NZC=00, Cnt=2: Branch=1, Jump=00; with PSW_NZC=11: Jump=01.
REQ-047 SHALL cover JALrr: InsM=10010xxx -> Cnt=2: WE_RF=1, PCplus1orWB=1, Jump=10, Buff_PC=1.
REQ-048 SHALL cover HLT: InsM=11100xxx, InsL=01 -> Cnt=2: Jump=11; then Done=1 until Rst, with Buff_MEMIns=0 and WE_* = 0.

Source files
------------

// File: rtl/ins_decoder.sv
// Instruction decoder / step sequencer for a multi-cycle CPU.
// Holds the instruction register and the halt flag; every control output is
// combinational from the external step counter, the held instruction,
// the PSW flags and the halt flag.
module ins_decoder (
  input  logic       clk,
  input  logic       Rst,
  input  logic [7:0] InsM,
  input  logic [1:0] InsL,
  input  logic [2:0] Cnt,
  input  logic [1:0] PSW_NZC,
  output logic       Flag,
  output logic       ALUop,
  output logic       Buff_PSW,
  output logic       Branch,
  output logic [1:0] Jump,
  output logic       Buff_PC,
  output logic       Buff_MEMIns,
  output logic       MEMresource,
  output logic       ALUorNot,
  output logic       LIorMOV,
  output logic       WE_MEM,
  output logic       WE_RF,
  output logic       PCplus1orWB,
  output logic       LI,
  output logic       WBresource,
  output logic       RBresource,
  output logic       OprandB,
  output logic       Done
);

  typedef enum logic [4:0] {
    OP_ALU    = 5'b00000,
    OP_LHI    = 5'b00001,
    OP_LLI    = 5'b00010,
    OP_LDRRI  = 5'b00011,
    OP_LDRRR  = 5'b00100,
    OP_STRRI  = 5'b00101,
    OP_STRCMP = 5'b00110,
    OP_ADDI   = 5'b00111,
    OP_SUBI   = 5'b01000,
    OP_MOV    = 5'b01011,
    OP_JMP    = 5'b10000,
    OP_JALRL  = 5'b10001,
    OP_JALRR  = 5'b10010,
    OP_JR     = 5'b10011,
    OP_BCOND  = 5'b11000,
    OP_BAL    = 5'b11001,
    OP_SYS    = 5'b11100
  } opcode_e;

  logic [9:0] ir_q, ir_d;
  logic       done_q, done_d;

  opcode_e    op;
  logic [2:0] cond;
  logic [1:0] fn;
  logic       is_alu, is_cmp, is_imm_alu, is_sub, is_carry;
  logic       is_ldr, is_str, is_ri, is_hlt, is_jal, taken;

  assign op   = opcode_e'(ir_q[9:5]);
  assign cond = ir_q[4:2];
  assign fn   = ir_q[1:0];

  // Instruction classification from the held IR.
  always_comb begin
    is_cmp     = (op == OP_STRCMP) && (fn == 2'b01);
    is_imm_alu = (op == OP_ADDI) || (op == OP_SUBI);
    is_alu     = (op == OP_ALU) || is_imm_alu || is_cmp;
    is_sub     = ((op == OP_ALU) && fn[1]) || (op == OP_SUBI) || is_cmp;
    is_carry   = (op == OP_ALU) && fn[0];
    is_ldr     = (op == OP_LDRRI) || (op == OP_LDRRR);
    is_str     = (op == OP_STRRI) || ((op == OP_STRCMP) && (fn == 2'b00));
    is_ri      = (op == OP_LDRRI) || (op == OP_STRRI);
    is_hlt     = (op == OP_SYS) && (fn == 2'b01);
    is_jal     = (op == OP_JALRL) || (op == OP_JALRR);
    case (cond)
      3'd0:    taken = ~PSW_NZC[1];
      3'd1:    taken =  PSW_NZC[1];
      3'd2:    taken =  PSW_NZC[0];
      3'd3:    taken = ~PSW_NZC[0];
      default: taken = 1'b0;
    endcase
    if (op == OP_BAL) taken = 1'b1;
  end

  // Next-state: IR loads at fetch, halt flag sets at HLT execute; both frozen once halted.
  always_comb begin
    ir_d   = ir_q;
    done_d = done_q;
    if (!done_q) begin
      if (Cnt == 3'd0) ir_d = {InsM, InsL};
      if ((Cnt == 3'd2) && is_hlt) done_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      ir_q   <= '0;
      done_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      done_q <= done_d;
    end
  end

  // Control outputs per step; all zero under reset and past an instruction's last step.
  always_comb begin
    Flag        = 1'b0;
    ALUop       = 1'b0;
    Buff_PSW    = 1'b0;
    Branch      = 1'b0;
    Jump        = 2'b00;
    Buff_PC     = 1'b0;
    Buff_MEMIns = 1'b0;
    MEMresource = 1'b0;
    ALUorNot    = 1'b0;
    LIorMOV     = 1'b0;
    WE_MEM      = 1'b0;
    WE_RF       = 1'b0;
    PCplus1orWB = 1'b0;
    LI          = 1'b0;
    WBresource  = 1'b0;
    RBresource  = 1'b0;
    OprandB     = 1'b0;
    Done        = 1'b0;
    if (Rst) begin
      Done = 1'b0;
    end else if (done_q) begin
      Buff_PC = 1'b1;
      Jump    = 2'b11;
      Done    = 1'b1;
    end else if (Cnt == 3'd0) begin
      Buff_MEMIns = 1'b1;
    end else if (Cnt != 3'd1) begin
      if (is_alu) begin
        if ((Cnt == 3'd2) || (Cnt == 3'd3)) begin
          ALUorNot = 1'b1;
          ALUop    = is_sub;
          Flag     = is_carry;
          OprandB  = is_imm_alu;
        end
        if (Cnt == 3'd3) begin
          Buff_PSW = 1'b1;
          Buff_PC  = 1'b1;
          WE_RF    = ~is_cmp;
        end
      end else if ((op == OP_LHI) || (op == OP_LLI) || (op == OP_MOV)) begin
        if (Cnt == 3'd2) begin
          WE_RF   = 1'b1;
          Buff_PC = 1'b1;
          LI      = (op == OP_LHI);
          LIorMOV = (op == OP_MOV);
        end
      end else if (is_ldr) begin
        if ((Cnt >= 3'd2) && (Cnt <= 3'd4)) OprandB = is_ri;
        if ((Cnt == 3'd3) || (Cnt == 3'd4)) MEMresource = 1'b1;
        if (Cnt == 3'd4) begin
          WBresource = 1'b1;
          WE_RF      = 1'b1;
          Buff_PC    = 1'b1;
        end
      end else if (is_str) begin
        if ((Cnt == 3'd2) || (Cnt == 3'd3)) begin
          OprandB    = is_ri;
          RBresource = 1'b1;
        end
        if (Cnt == 3'd3) begin
          MEMresource = 1'b1;
          WE_MEM      = 1'b1;
          Buff_PC     = 1'b1;
        end
      end else if (Cnt == 3'd2) begin
        Buff_PC = 1'b1;
        if ((op == OP_BCOND) || (op == OP_BAL)) begin
          Branch = 1'b1;
          Jump   = taken ? 2'b01 : 2'b00;
        end else if ((op == OP_JMP) || (op == OP_JALRL)) begin
          Jump = 2'b01;
        end else if ((op == OP_JALRR) || (op == OP_JR)) begin
          Jump = 2'b10;
        end else if (is_hlt) begin
          Jump = 2'b11;
        end
        if (is_jal) begin
          WE_RF       = 1'b1;
          PCplus1orWB = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ins_decoder.sv
// Self-checking bench for ins_decoder: directed scenarios plus randomized
// instruction/step/flag streams compared against a behavioural model.
module tb_ins_decoder;

  logic       clk = 1'b0;
  logic       Rst;
  logic [7:0] InsM;
  logic [1:0] InsL;
  logic [2:0] Cnt;
  logic [1:0] PSW_NZC;
  logic       Flag, ALUop, Buff_PSW, Branch, Buff_PC, Buff_MEMIns, MEMresource;
  logic       ALUorNot, LIorMOV, WE_MEM, WE_RF, PCplus1orWB, LI, WBresource;
  logic       RBresource, OprandB, Done;
  logic [1:0] Jump;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [9:0] m_ir   = '0;
  logic       m_done = 1'b0;

  ins_decoder dut (
    .clk(clk), .Rst(Rst), .InsM(InsM), .InsL(InsL), .Cnt(Cnt), .PSW_NZC(PSW_NZC),
    .Flag(Flag), .ALUop(ALUop), .Buff_PSW(Buff_PSW), .Branch(Branch), .Jump(Jump),
    .Buff_PC(Buff_PC), .Buff_MEMIns(Buff_MEMIns), .MEMresource(MEMresource),
    .ALUorNot(ALUorNot), .LIorMOV(LIorMOV), .WE_MEM(WE_MEM), .WE_RF(WE_RF),
    .PCplus1orWB(PCplus1orWB), .LI(LI), .WBresource(WBresource),
    .RBresource(RBresource), .OprandB(OprandB), .Done(Done)
  );

  always #5 clk = ~clk;

  logic [18:0] outv;
  assign outv = {Flag, ALUop, Buff_PSW, Branch, Jump, Buff_PC, Buff_MEMIns, MEMresource,
                 ALUorNot, LIorMOV, WE_MEM, WE_RF, PCplus1orWB, LI, WBresource,
                 RBresource, OprandB, Done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control word derived from the instruction table, one step at a time.
  function automatic logic [18:0] model(input logic [9:0] ir, input logic [2:0] cnt,
                                        input logic [1:0] psw, input logic done,
                                        input logic rst);
    logic fl, sub, psw_we, br, pc, fetch, mres, alu, mov, wem, werf, link, li, wb, rb, imm, dn;
    logic [1:0] jmp;
    logic [4:0] op;
    logic [1:0] fn;
    int unsigned kind;   // 0 nop,1 alu,2 li/mov,3 ldr,4 str,5 branch,6 jump,7 hlt
    int unsigned last;
    logic tk;
    {fl, sub, psw_we, br, pc, fetch, mres, alu, mov, wem, werf, link, li, wb, rb, imm, dn} = '0;
    jmp = 2'b00;
    op = ir[9:5];
    fn = ir[1:0];
    kind = 0;
    if (op == 5'd0 || op == 5'd7 || op == 5'd8 || (op == 5'd6 && fn == 2'd1)) kind = 1;
    else if (op == 5'd1 || op == 5'd2 || op == 5'd11) kind = 2;
    else if (op == 5'd3 || op == 5'd4) kind = 3;
    else if (op == 5'd5 || (op == 5'd6 && fn == 2'd0)) kind = 4;
    else if (op == 5'd24 || op == 5'd25) kind = 5;
    else if (op >= 5'd16 && op <= 5'd19) kind = 6;
    else if (op == 5'd28 && fn == 2'd1) kind = 7;
    last = (kind == 1 || kind == 4) ? 3 : (kind == 3) ? 4 : 2;
    if (rst) begin
      // everything low
    end else if (done) begin
      pc = 1; jmp = 2'b11; dn = 1;
    end else if (cnt == 0) begin
      fetch = 1;
    end else if (cnt >= 2 && cnt <= last) begin
      pc = (cnt == last);
      case (kind)
        1: begin
          alu = 1;
          sub = (op == 5'd0 && fn >= 2) || op == 5'd8 || op == 5'd6;
          fl  = (op == 5'd0 && (fn == 1 || fn == 3));
          imm = (op == 5'd7 || op == 5'd8);
          psw_we = (cnt == 3);
          werf = (cnt == 3) && (op != 5'd6);
        end
        2: begin werf = 1; li = (op == 5'd1); mov = (op == 5'd11); end
        3: begin
          imm = (op == 5'd3);
          mres = (cnt >= 3);
          wb = (cnt == 4); werf = (cnt == 4);
        end
        4: begin
          imm = (op == 5'd5); rb = 1;
          mres = (cnt == 3); wem = (cnt == 3);
        end
        5: begin
          br = 1;
          case (ir[4:2])
            3'd0: tk = !psw[1];
            3'd1: tk = psw[1];
            3'd2: tk = psw[0];
            3'd3: tk = !psw[0];
            default: tk = 0;
          endcase
          if (op == 5'd25) tk = 1;
          jmp = tk ? 2'b01 : 2'b00;
        end
        6: begin
          jmp = (op <= 5'd17) ? 2'b01 : 2'b10;
          werf = (op == 5'd17 || op == 5'd18);
          link = werf;
        end
        7: jmp = 2'b11;
        default: ;
      endcase
    end
    return {fl, sub, psw_we, br, jmp, pc, fetch, mres, alu, mov, wem, werf, link, li, wb, rb, imm, dn};
  endfunction

  // Drive one step's inputs and compare the whole control word at the opposite edge.
  task automatic apply(input logic rst, input logic [2:0] cnt, input logic [7:0] m,
                       input logic [1:0] l, input logic [1:0] psw, input string tag);
    Rst = rst; Cnt = cnt; InsM = m; InsL = l; PSW_NZC = psw;
    @(negedge clk);
    check(tag, {13'd0, outv}, {13'd0, model(m_ir, cnt, psw, m_done, rst)});
  endtask

  // Advance one clock and update the model state from the same inputs.
  task automatic tick();
    @(posedge clk);
    if (Rst) begin
      m_ir = '0; m_done = 1'b0;
    end else if (!m_done) begin
      if (Cnt == 3'd0) m_ir = {InsM, InsL};
      if (Cnt == 3'd2 && m_ir[9:5] == 5'b11100 && m_ir[1:0] == 2'b01) m_done = 1'b1;
    end
    #1;
  endtask

  // Full step walk 0..6 for one instruction with fixed flags.
  task automatic run_ins(input logic [7:0] m, input logic [1:0] l, input logic [1:0] psw,
                         input string tag);
    for (int unsigned s = 0; s < 7; s++) begin
      apply(1'b0, 3'(s), m, l, psw, $sformatf("%s_c%0d", tag, s));
      tick();
    end
  endtask

  logic [4:0] ops [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                           5'd11, 5'd16, 5'd17, 5'd18, 5'd19, 5'd24, 5'd25, 5'd28, 5'd28};

  initial begin
    logic [2:0] c;
    logic [7:0] m;
    Rst = 1'b1; Cnt = '0; InsM = '0; InsL = '0; PSW_NZC = '0;

    // Reset held two cycles with busy-looking inputs
    apply(1'b1, 3'd0, 8'hE0, 2'b01, 2'b11, "rst0"); tick();
    apply(1'b1, 3'd3, 8'h18, 2'b00, 2'b11, "rst1");
    check("rst_all_zero", {13'd0, outv}, 32'd0);
    tick();

    // ADD
    apply(1'b0, 3'd0, 8'b00000_101, 2'b00, 2'b00, "add_c0");
    check("post_rst_fetch", {31'd0, Buff_MEMIns}, 32'd1);
    tick();
    apply(1'b0, 3'd1, 8'hFF, 2'b11, 2'b00, "add_c1"); tick();
    apply(1'b0, 3'd2, 8'hFF, 2'b11, 2'b00, "add_c2");
    check("add_c2_alu_sub", {30'd0, ALUorNot, ALUop}, 32'b10);
    tick();
    apply(1'b0, 3'd3, 8'hFF, 2'b11, 2'b00, "add_c3");
    check("add_c3_wr", {27'd0, WE_RF, Buff_PSW, Buff_PC, Jump}, 32'b11100);
    tick();
    apply(1'b0, 3'd4, 8'hFF, 2'b11, 2'b00, "add_c4"); tick();

    // LDRri
    run_ins(8'b00011_010, 2'b10, 2'b00, "ldrri");
    // BEQ not taken / taken
    run_ins(8'b11000_001, 2'b00, 2'b00, "beq_nt");
    run_ins(8'b11000_001, 2'b00, 2'b11, "beq_t");
    // JALrr
    run_ins(8'b10010_000, 2'b00, 2'b00, "jalrr");
    // A handful of other classes
    run_ins(8'b00110_000, 2'b01, 2'b00, "cmp");
    run_ins(8'b00110_000, 2'b00, 2'b00, "strrr");
    run_ins(8'b00001_000, 2'b00, 2'b00, "lhi");
    run_ins(8'b11100_000, 2'b00, 2'b00, "outr");
    run_ins(8'b00000_000, 2'b11, 2'b00, "sbb");

    // HLT then sticky Done
    run_ins(8'b11100_000, 2'b01, 2'b00, "hlt");
    apply(1'b0, 3'd0, 8'h00, 2'b00, 2'b00, "halted_c0");
    check("halted_state", {26'd0, Done, Buff_MEMIns, WE_RF, WE_MEM, Jump}, 32'b100011);
    tick();
    run_ins(8'b00000_000, 2'b00, 2'b00, "halted");
    apply(1'b1, 3'd2, 8'h00, 2'b00, 2'b00, "halt_rst"); tick();
    apply(1'b0, 3'd0, 8'h00, 2'b00, 2'b00, "after_halt_rst");
    check("halt_cleared", {31'd0, Done}, 32'd0);
    tick();

    // Randomized streams
    c = 3'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) c = 3'($urandom_range(0, 7));
      else c = (c >= 3'd5) ? 3'd0 : c + 3'd1;
      if ($urandom_range(0, 3) == 0) m = 8'($urandom);
      else m = {ops[$urandom_range(0, 17)], 3'($urandom)};
      apply(($urandom_range(0, 59) == 0), c, m, 2'($urandom), 2'($urandom),
            $sformatf("rand%0d", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
